// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: sequencing FSM for a read-only, FIFO-fed I2C slave transmitter.
// Drives the SDA output select, rx/tx shift enables, FIFO pops, byte count and underrun flag.
module i2c_slave_ctrl #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_found,
    input  logic             stop_found,
    input  logic             byte_received,
    input  logic             ack_prep,
    input  logic             check_ack,
    input  logic             ack_done,
    input  logic             rw_mode,
    input  logic             address_match,
    input  logic             sda_in,
    input  logic             tx_empty,
    output logic             rx_enable,
    output logic             tx_enable,
    output logic             load_data,
    output logic             read_enable,
    output logic [1:0]       sda_mode,
    output logic [CNT_W-1:0] byte_count,
    output logic             underrun
);
    typedef enum logic [3:0] {
        IDLE, ADDR, CHECK, ACK_WAIT, ACK, NACK_WAIT, NACK, LOAD, TX, MACK, MACK_END
    } state_t;
    state_t state, next_state;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else        state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = start_found ? ADDR : IDLE;
            ADDR:      next_state = byte_received ? CHECK : ADDR;
            CHECK:     next_state = (address_match && rw_mode) ? ACK_WAIT : NACK_WAIT;
            ACK_WAIT:  next_state = ack_prep ? ACK : ACK_WAIT;
            ACK:       next_state = ack_done ? LOAD : ACK;
            NACK_WAIT: next_state = ack_prep ? NACK : NACK_WAIT;
            NACK:      next_state = ack_done ? IDLE : NACK;
            LOAD:      next_state = TX;
            TX:        next_state = ack_prep ? MACK : TX;
            MACK:      next_state = check_ack ? (sda_in ? IDLE : MACK_END) : MACK;
            MACK_END:  next_state = ack_done ? LOAD : MACK_END;
            default:   next_state = IDLE;
        endcase
        if (start_found) next_state = ADDR;
        if (stop_found)  next_state = IDLE;
        rx_enable   = state == ADDR;
        tx_enable   = state == TX;
        load_data   = state == LOAD;
        read_enable = state == LOAD && !tx_empty;
        sda_mode    = state == ACK  ? 2'b01 :
                      state == NACK ? 2'b10 :
                      state == TX   ? 2'b11 : 2'b00;
    end
    // A START that is not overridden by STOP enters ADDR, which starts a fresh transfer
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            byte_count <= '0;
            underrun   <= 1'b0;
        end else if (start_found && !stop_found) begin
            byte_count <= '0;
            underrun   <= 1'b0;
        end else if (state == LOAD) begin
            if (~&byte_count) byte_count <= byte_count + CNT_W'(1);
            underrun <= underrun | tx_empty;
        end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: randomized transaction-level bench for i2c_slave_ctrl.
// A byte-level model predicts each FIFO load; a monitor checks loads against a queue.
module tb_i2c_slave_ctrl;
    localparam int E_START = 0, E_STOP = 1, E_BYTE = 2, E_PREP = 3, E_CHK = 4, E_DONE = 5;
    localparam int AB_NONE = 0, AB_STOP = 1, AB_RESTART = 2, AB_RESET = 3;
    localparam int EM_NEVER = 0, EM_RAND = 1, EM_SECOND = 2;

    logic clk = 0, n_rst = 0;
    logic start_found = 0, stop_found = 0, byte_received = 0, ack_prep = 0;
    logic check_ack = 0, ack_done = 0, rw_mode = 0, address_match = 0, sda_in = 0, tx_empty = 0;
    logic rx_enable, tx_enable, load_data, read_enable, underrun;
    logic [1:0] sda_mode;
    logic [4:0] byte_count;

    int n_tests = 0, n_fail = 0;

    typedef struct {
        logic       re;
        logic [4:0] cnt;
    } ld_t;
    ld_t sb[$];

    i2c_slave_ctrl dut (
        .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
        .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
        .ack_done(ack_done), .rw_mode(rw_mode), .address_match(address_match),
        .sda_in(sda_in), .tx_empty(tx_empty), .rx_enable(rx_enable), .tx_enable(tx_enable),
        .load_data(load_data), .read_enable(read_enable), .sda_mode(sda_mode),
        .byte_count(byte_count), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every load pulse must match the oldest predicted load
    always @(negedge clk) begin
        #2;
        if (n_rst && load_data) begin
            if (sb.size() == 0) chk("unexpected_load", 1, 0);
            else begin
                ld_t e;
                e = sb.pop_front();
                chk("load_read_enable", read_enable, e.re);
                chk("load_count_before", byte_count, e.cnt);
            end
        end
    end

    task automatic ev(input int e);
        @(negedge clk);
        case (e)
            E_START: start_found   = 1;
            E_STOP:  stop_found    = 1;
            E_BYTE:  byte_received = 1;
            E_PREP:  ack_prep      = 1;
            E_CHK:   check_ack     = 1;
            default: ack_done      = 1;
        endcase
        @(negedge clk);
        {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int sat(input int v);
        return v > 31 ? 31 : v;
    endfunction

    task automatic txn(input bit m, input bit rw, input int n, input int em, input int ab, input int k);
        bit ur;
        bit emp;
        ur = 0;
        ev(E_START);
        chk("addr_count_clear", byte_count, 0);
        chk("addr_underrun_clear", underrun, 0);
        chk("addr_rx_enable", rx_enable, 1);
        idle($urandom_range(0, 3));
        address_match = m;
        rw_mode = rw;
        ev(E_BYTE);
        idle($urandom_range(0, 2));
        ev(E_PREP);
        chk("addr_ack_slot_sda", sda_mode, (m && rw) ? 1 : 2);
        idle($urandom_range(0, 2));
        if (!(m && rw)) begin
            ev(E_DONE);
            idle(2);
            chk("nack_then_idle_sda", sda_mode, 0);
            chk("nack_count", byte_count, 0);
            ev(E_STOP);
            return;
        end
        for (int i = 0; i < n; i++) begin
            emp = em == EM_RAND ? ($urandom_range(0, 3) == 0) : (em == EM_SECOND && i == 1);
            tx_empty = emp;
            sb.push_back('{re: !emp, cnt: 5'(sat(i))});
            ur |= emp;
            ev(E_DONE);
            idle(1);
            chk("tx_sda", sda_mode, 3);
            chk("tx_enable", tx_enable, 1);
            chk("tx_count", byte_count, sat(i + 1));
            chk("tx_underrun", underrun, ur);
            if (ab == AB_STOP && i == k) begin
                ev(E_STOP);
                chk("stop_in_tx_sda", sda_mode, 0);
                chk("stop_in_tx_txen", tx_enable, 0);
                ev(E_PREP);
                ev(E_DONE);
                idle(2);
                chk("stop_underrun_held", underrun, ur);
                return;
            end
            if (ab == AB_RESET && i == k) begin
                @(negedge clk);
                #2 n_rst = 0;
                #1;
                chk("reset_in_tx_sda", sda_mode, 0);
                chk("reset_in_tx_txen", tx_enable, 0);
                chk("reset_in_tx_count", byte_count, 0);
                chk("reset_in_tx_underrun", underrun, 0);
                @(negedge clk) n_rst = 1;
                idle(1);
                chk("after_reset_sda", sda_mode, 0);
                return;
            end
            idle($urandom_range(0, 4));
            ev(E_PREP);
            chk("mack_release_sda", sda_mode, 0);
            if (ab == AB_RESTART && i == k) begin
                ev(E_START);
                chk("restart_count", byte_count, 0);
                chk("restart_underrun", underrun, 0);
                chk("restart_rx_enable", rx_enable, 1);
                ev(E_STOP);
                return;
            end
            idle($urandom_range(0, 2));
            sda_in = (i == n - 1);
            ev(E_CHK);
            chk("mack_end_sda", sda_mode, 0);
            idle($urandom_range(0, 2));
        end
        ev(E_DONE);
        idle(2);
        chk("end_idle_sda", sda_mode, 0);
        chk("end_count", byte_count, sat(n));
        ev(E_STOP);
        chk("stop_underrun_held", underrun, ur);
        chk("stop_count_held", byte_count, sat(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_sda", sda_mode, 0);
        chk("rst_rx", rx_enable, 0);
        chk("rst_tx", tx_enable, 0);
        chk("rst_load", load_data, 0);
        chk("rst_read", read_enable, 0);
        chk("rst_count", byte_count, 0);
        chk("rst_underrun", underrun, 0);
        n_rst = 1;
        idle(2);
        txn(1, 1, 1, EM_NEVER, AB_NONE, 0);
        txn(0, 1, 1, EM_NEVER, AB_NONE, 0);
        txn(1, 0, 1, EM_NEVER, AB_NONE, 0);
        txn(1, 1, 3, EM_NEVER, AB_NONE, 0);
        txn(1, 1, 3, EM_SECOND, AB_NONE, 0);
        txn(1, 1, 40, EM_NEVER, AB_NONE, 0);
        txn(1, 1, 2, EM_NEVER, AB_STOP, 1);
        txn(1, 1, 3, EM_SECOND, AB_RESTART, 1);
        txn(1, 1, 2, EM_NEVER, AB_RESET, 0);
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 6);
            txn($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, n, EM_RAND,
                $urandom_range(0, 5) < 3 ? AB_NONE : $urandom_range(1, 3), $urandom_range(0, n - 1));
        end
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
